// File: rtl/addsub_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : addsub_seq_pkg
//  Purpose  : Shared definitions for addsub_seq. Holds the FSM state encoding
//             and the default operand and chunk widths.
//  Revision : 1.0  initial release
// ============================================================================
package addsub_seq_pkg;

   // Default operand width and chunk width processed per cycle
   localparam int ADDSUB_N_DEF = 32;
   localparam int ADDSUB_K_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage
`default_nettype wire

// File: rtl/addsub_seq_adder.sv
`default_nettype none
// ============================================================================
//  Module   : addsub_seq_adder
//  Purpose  : Plain W-bit ripple adder with carry in and carry out. Used as
//             the chunk datapath of addsub_seq.
//  Revision : 1.0  initial release
// ============================================================================
module addsub_seq_adder #(
   parameter int W = 8
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         ci_i,
   output logic [W-1:0] s_o,
   output logic         co_o
);

   // Single wide addition gives both the sum bits and the carry out
   assign {co_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, ci_i};

endmodule
`default_nettype wire

// File: rtl/addsub_seq.sv
`default_nettype none
// ============================================================================
//  Module   : addsub_seq
//  Purpose  : Sequential N-bit adder/subtractor that processes K bits per
//             cycle (N/K cycles per operation) with a valid/ready handshake
//             on both sides. The result and flags are held until consumed.
//  Options  : ADDSUB_SAT_EN - adds a 'sat' input. When it is set, a signed
//             overflow clamps the result to the most positive or most
//             negative value.
//  Revision : 1.0  initial release
// ============================================================================
module addsub_seq
   import addsub_seq_pkg::*;
#(
   parameter int N = ADDSUB_N_DEF,
   parameter int K = ADDSUB_K_DEF
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         sub,
   input  logic         cin,
`ifdef ADDSUB_SAT_EN
   input  logic         sat,
`endif
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] sum,
   output logic         cout,
   output logic         overflow,
   output logic         zero,
   output logic         negative
);

   localparam int NCH = N / K;
   localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

   state_e         state_q;
   logic [IW-1:0]  idx_q;
   logic [N-1:0]   a_q, b_q;      // shift right by K each RUN cycle
   logic [N-1:0]   res_q;         // result accumulates from the top down
   logic           sub_q, carry_q;
   logic           in_ready_q, out_valid_q;
   logic [N-1:0]   sum_q;
   logic           cout_q, ovf_q, zero_q, neg_q;
`ifdef ADDSUB_SAT_EN
   logic           sat_q, amsb_q;
`endif

   // Datapath signals for the current chunk
   logic [K-1:0]   bx;
   logic [K-1:0]   full_s;
   logic           full_co;
   logic [K-2:0]   lo_s;
   logic           lo_co;
   logic           msb_s, msb_co;
   logic           last;
   logic [K-1:0]   chunk_d;
   logic           carry_d;
   logic [N-1:0]   res_d;
   logic [N-1:0]   sum_d;
   logic           ovf_d;

   // Chunk in the middle of the word: one K-bit adder
   addsub_seq_adder #(.W(K)) u_full (
      .a_i  (a_q[K-1:0]),
      .b_i  (bx),
      .ci_i (carry_q),
      .s_o  (full_s),
      .co_o (full_co)
   );

   // Last chunk: K-1 low bits, then the sign bit alone, so the carry into
   // the MSB is visible for signed overflow detection
   addsub_seq_adder #(.W(K-1)) u_lo (
      .a_i  (a_q[K-2:0]),
      .b_i  (bx[K-2:0]),
      .ci_i (carry_q),
      .s_o  (lo_s),
      .co_o (lo_co)
   );

   addsub_seq_adder #(.W(1)) u_msb (
      .a_i  (a_q[K-1]),
      .b_i  (bx[K-1]),
      .ci_i (lo_co),
      .s_o  (msb_s),
      .co_o (msb_co)
   );

   // Select the chunk result, merge it into the accumulated word, apply clamp
   always_comb begin
      bx      = b_q[K-1:0] ^ {K{sub_q}};
      last    = (idx_q == IW'(NCH - 1));
      chunk_d = last ? {msb_s, lo_s} : full_s;
      carry_d = last ? msb_co : full_co;
      res_d   = (res_q >> K) | (N'(chunk_d) << (N - K));
      ovf_d   = lo_co ^ msb_co;
      sum_d   = res_d;
`ifdef ADDSUB_SAT_EN
      if (sat_q && ovf_d) begin
         sum_d = {amsb_q, {(N-1){~amsb_q}}};
      end
`endif
   end

   // Control FSM with registered handshake outputs, result and flags
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         res_q       <= '0;
         sub_q       <= 1'b0;
         carry_q     <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         zero_q      <= 1'b0;
         neg_q       <= 1'b0;
`ifdef ADDSUB_SAT_EN
         sat_q       <= 1'b0;
         amsb_q      <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  a_q        <= a;
                  b_q        <= b;
                  sub_q      <= sub;
                  carry_q    <= cin ^ sub;
                  idx_q      <= '0;
`ifdef ADDSUB_SAT_EN
                  sat_q      <= sat;
                  amsb_q     <= a[N-1];
`endif
                  in_ready_q <= 1'b0;
                  state_q    <= ST_RUN;
               end
            end
            ST_RUN: begin
               a_q     <= a_q >> K;
               b_q     <= b_q >> K;
               carry_q <= carry_d;
               res_q   <= res_d;
               idx_q   <= idx_q + IW'(1);
               if (last) begin
                  sum_q       <= sum_d;
                  cout_q      <= msb_co ^ sub_q;
                  ovf_q       <= ovf_d;
                  zero_q      <= (sum_d == '0);
                  neg_q       <= sum_d[N-1];
                  out_valid_q <= 1'b1;
                  state_q     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign overflow  = ovf_q;
   assign zero      = zero_q;
   assign negative  = neg_q;

endmodule
`default_nettype wire
